clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised N-channel programmable clock divider for the PWM subsystem.
- Each channel divides clk_i by any integer D ≥ 1, odd or even, and produces two outputs:
  - a near-50% duty divided-clock level, registered and single-edge.
  - a one-cycle period tick, used as a clock enable.
- All logic runs on clk_i posedge only. No derived clocks and no negedge logic; downstream logic uses o_tick as an enable.
- A global restart phase-aligns all channels.

Parameters:
- NCH, 4, number of independent channels (≥1).
- W, 16, divisor width in bits per channel (≥2).

Ports:
- clk_i  input  1  system clock, posedge only.
- rst_ni  input  1  synchronous, active-low reset.
- i_divisor  input  NCH*W  packed divisors; channel k is bits [k*W +: W].
- i_enable  input  NCH  per-channel run enable.
- i_restart  input  1  single-cycle pulse; restarts all channels at phase 0.
- o_clk  output  NCH  divided level per channel, registered.
- o_tick  output  NCH  one-cycle pulse on the last cycle of each period, registered.

Behaviour:
- Reset, while rst_ni=0 at posedge:
  - every cnt=0; o_clk=0; o_tick=0; shadow divisors=0.
  - Reset wins over all other inputs.
- Per channel, with D = effective divisor and active = i_enable && D≠0:
  - Counter cnt is W bits wide.
  - Next cnt is 0 when any of these hold: !active, i_restart, or cnt ≥ D−1. Otherwise next cnt is cnt+1.
  - The "≥" comparison recovers safely when D shrinks below cnt.
  - High count H = (D+1)>>1, computed in W+1 bits so that D = 2^W−1 does not overflow.
  - For odd D, high is 1 cycle longer than low.
- Registered outputs, one cycle latency from cnt:
  - o_clk <= active && !i_restart && (cnt < H).
  - o_tick <= active && !i_restart && (cnt == D−1).
- Resulting waveform for D ≥ 2, period D cycles:
  - o_clk is high for H cycles, then low for D−H cycles.
  - o_tick is high for exactly 1 cycle per period, on o_clk's last low cycle.
- D=1: cnt stays 0; o_clk=1 and o_tick=1 every cycle while active.
- D=0: the channel is idle; o_clk=0 and o_tick=0. This is a disabled state, not a clock passthrough.
- Enable deassert: on the next edge cnt=0 and outputs go to 0. On re-enable the channel starts at phase 0, so the first o_clk high appears 1 cycle after enable.
- i_restart:
  - Takes effect on all active channels in the same cycle: cnt=0 and outputs forced 0 for that cycle.
  - Channels with identical D are then phase-identical.
  - If i_restart coincides with an enable edge, restart takes priority.
- Channels are fully independent apart from clk_i, rst_ni and i_restart.

Optional Feature:
- Macro: CLK_DIV_SYNC_UPDATE_EN.
- Defined:
  - Each channel holds a W-bit shadow divisor, which is the effective D.
  - The shadow loads i_divisor only when the channel wraps (cnt ≥ D−1), when the channel is inactive, or on i_restart.
  - A divisor change mid-period therefore completes the current period at the old D, giving no runt or stretched pulse.
- Undefined:
  - D = i_divisor directly, and changes take effect at the next edge.
  - A shrink below cnt produces a single truncated period through the ≥ wrap.
  - No shadow registers.

Decomposition:
- Package clk_div_pkg contains:
  - localparam default divisor width 16.
  - function half_hi(D), returning the W+1-bit (D+1)>>1.
  - constant CLK_DIV_IDLE = 0.
- Sub-module clk_div_chan holds one channel: counter, optional shadow and output flops.
- The top generates NCH instances and slices i_divisor.

Test Plan:
- D=5, enable held from cycle 0 → o_clk repeats 1,1,1,0,0 with period 5. o_tick high on cycle 4 of each period. Exactly 3 high cycles per period.
- D=4 on channel 0 and D=7 on channel 1, then i_restart pulse at cycle 20 → both channels show o_clk=0 and o_tick=0 at cycle 21. Their first high follows in lockstep from phase 0, and ch1 periods then last 7 cycles (4 high, 3 low).
- D=1, then D=0 → o_clk=o_tick=1 every cycle; after the switch to 0, both are 0 from the next cycle onward.
- D=10 running, change to D=3 at cnt=6:
  - without macro, wrap at the next edge and 3-cycle periods thereafter.
  - with CLK_DIV_SYNC_UPDATE_EN, the current 10-cycle period completes, then 3-cycle periods (2 high, 1 low).
- rst_ni=0 for 1 cycle mid-period with D=9 → all outputs 0 the next cycle. After release the channel restarts at phase 0 with the first tick 9 cycles later.
- D=16'hFFFF → H=32768 with no overflow. o_clk is high 32768 cycles and low 32767 cycles.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_multi shared definitions.
// Holds the default divisor width, the idle divisor and the high-count helper.
package clk_div_pkg;

    localparam int CLK_DIV_W_DEF = 16;
    localparam int CLK_DIV_IDLE  = 0;

    // One extra bit so that an all-ones divisor rounds up without wrapping.
    function automatic logic [32:0] half_hi(input logic [31:0] d);
        return ({1'b0, d} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, optional shadow divisor, output flops.
// CLK_DIV_SYNC_UPDATE_EN defers divisor changes to the period boundary.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W = CLK_DIV_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] i_divisor,
    input  logic         i_enable,
    input  logic         i_restart,
    output logic         o_clk,
    output logic         o_tick
);

    logic [W-1:0] cnt;
    logic [W-1:0] d_eff;
    logic [W-1:0] d_m1;
    logic [32:0]  hi_cnt;
    logic [32:0]  cnt_x;
    logic         active;
    logic         wrap;

`ifdef CLK_DIV_SYNC_UPDATE_EN
    logic [W-1:0] shadow;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow <= '0;
        end else if (wrap || !active || i_restart) begin
            shadow <= i_divisor;
        end
    end

    assign d_eff = shadow;
`else
    assign d_eff = i_divisor;
`endif

    assign d_m1   = d_eff - W'(1);
    assign active = i_enable && (d_eff != W'(CLK_DIV_IDLE));
    // ">=" rather than "==" so a divisor shrinking below cnt still wraps.
    assign wrap   = cnt >= d_m1;
    assign hi_cnt = half_hi(32'(d_eff));
    assign cnt_x  = 33'(cnt);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt    <= '0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            if (!active || i_restart || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
            o_clk  <= active && !i_restart && (cnt_x < hi_cnt);
            o_tick <= active && !i_restart && (cnt == d_m1);
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider producing levels and period ticks.
// Build with CLK_DIV_SYNC_UPDATE_EN for glitch-free divisor updates.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = CLK_DIV_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NCH*W-1:0] i_divisor,
    input  logic [NCH-1:0]   i_enable,
    input  logic             i_restart,
    output logic [NCH-1:0]   o_clk,
    output logic [NCH-1:0]   o_tick
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        clk_div_chan #(
            .W(W)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .i_divisor(i_divisor[k*W +: W]),
            .i_enable (i_enable[k]),
            .i_restart(i_restart),
            .o_clk    (o_clk[k]),
            .o_tick   (o_tick[k])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: vector table, corner sequences
// and a randomized run against a period-arithmetic reference model.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [NCH*W-1:0] i_divisor;
    logic [NCH-1:0]   i_enable;
    logic             i_restart;
    logic [NCH-1:0]   o_clk;
    logic [NCH-1:0]   o_tick;

    clk_div_multi #(.NCH(NCH), .W(W)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_divisor(i_divisor),
        .i_enable (i_enable),
        .i_restart(i_restart),
        .o_clk    (o_clk),
        .o_tick   (o_tick)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] d;
        logic        en;
        logic        rs;
        logic        ck;
        logic        tk;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_div(input int ch, input logic [15:0] d);
        i_divisor[ch*W +: W] = d;
    endtask

    // Reference model: phase = cycles since the channel last (re)started.
    int          m_start [NCH];
    int          m_d     [NCH];
    int          n_edge;
    logic [NCH-1:0] e_clk, e_tick;

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit act;
            int ph;
            act = i_enable[c] && (m_d[c] != 0);
            if (!act || i_restart) begin
                e_clk[c]   = 1'b0;
                e_tick[c]  = 1'b0;
                m_start[c] = n_edge + 1;
            end else begin
                ph = (n_edge - m_start[c]) % m_d[c];
                e_clk[c]  = ph < (m_d[c] + 1) / 2;
                e_tick[c] = ph == m_d[c] - 1;
            end
        end
        n_edge++;
    endtask

    vec_t tbl[$];
    int   ck_seq[7];
    int   tk_seq[7];

    initial begin
        int wait_n;
        int hi;
        int ticks;
        int tick_at;
        bit mid_hi;
        bit mid_lo;

        i_divisor = '0;
        i_enable  = '0;
        i_restart = 1'b0;
        rst_ni    = 1'b0;
        step();
        step();
        chk("reset_clk", 32'(o_clk), 32'd0);
        chk("reset_tick", 32'(o_tick), 32'd0);
        rst_ni = 1'b1;

        // Channel 0 vector table
        tbl.push_back('{16'd5, 1'b1, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++)
            tbl.push_back('{16'd5, 1'b1, 1'b0, (i % 5) < 3, (i % 5) == 4});
        tbl.push_back('{16'd1, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16'd1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{16'd1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{16'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{16'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{16'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{16'd5, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{16'd5, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{16'd5, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{16'd5, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{16'd5, 1'b1, 1'b0, 1'b0, 1'b0});
        foreach (tbl[i]) begin
            set_div(0, tbl[i].d);
            i_enable[0] = tbl[i].en;
            i_restart   = tbl[i].rs;
            step();
            chk($sformatf("tbl%0d_clk", i), 32'(o_clk[0]), 32'(tbl[i].ck));
            chk($sformatf("tbl%0d_tick", i), 32'(o_tick[0]), 32'(tbl[i].tk));
        end
        i_restart = 1'b0;

        // Restart lockstep: ch0 D=4, ch1 D=7
        set_div(0, 16'd4);
        set_div(1, 16'd7);
        i_enable  = 4'b0011;
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        for (int i = 0; i < 19; i++) step();
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        chk("rst_pulse_clk", 32'(o_clk[1:0]), 32'd0);
        chk("rst_pulse_tick", 32'(o_tick[1:0]), 32'd0);
        for (int k = 0; k < 14; k++) begin
            step();
            chk($sformatf("ls%0d_c0", k), 32'(o_clk[0]), 32'((k % 4) < 2));
            chk($sformatf("ls%0d_t0", k), 32'(o_tick[0]), 32'((k % 4) == 3));
            chk($sformatf("ls%0d_c1", k), 32'(o_clk[1]), 32'((k % 7) < 4));
            chk($sformatf("ls%0d_t1", k), 32'(o_tick[1]), 32'((k % 7) == 6));
        end

        // Divisor change 10 -> 3 at cnt=6 on channel 0
`ifdef CLK_DIV_SYNC_UPDATE_EN
        ck_seq = '{0, 0, 0, 0, 1, 1, 0};
        tk_seq = '{0, 0, 0, 1, 0, 0, 1};
`else
        ck_seq = '{0, 1, 1, 0, 1, 1, 0};
        tk_seq = '{0, 0, 0, 1, 0, 0, 1};
`endif
        i_enable  = 4'b0001;
        set_div(0, 16'd10);
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("pre%0d_clk", k), 32'(o_clk[0]), 32'(k < 5));
        end
        set_div(0, 16'd3);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("chg%0d_clk", k), 32'(o_clk[0]), 32'(ck_seq[k]));
            chk($sformatf("chg%0d_tick", k), 32'(o_tick[0]), 32'(tk_seq[k]));
        end

        // Mid-period reset with D=9
        set_div(0, 16'd9);
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("midrst_clk", 32'(o_clk), 32'd0);
        chk("midrst_tick", 32'(o_tick), 32'd0);
        wait_n = 0;
        while (wait_n < 20) begin
            step();
            wait_n++;
            if (o_tick[0]) break;
        end
`ifdef CLK_DIV_SYNC_UPDATE_EN
        chk("midrst_first_tick", 32'(wait_n), 32'd10);
`else
        chk("midrst_first_tick", 32'(wait_n), 32'd9);
`endif

        // Randomized run against the reference model
        i_enable  = '0;
        for (int c = 0; c < NCH; c++) begin
            m_d[c] = $urandom_range(0, 12);
            set_div(c, 16'(m_d[c]));
        end
        n_edge    = 0;
        i_restart = 1'b1;
        model_edge();
        step();
        for (int t = 0; t < 1500; t++) begin
            int r;
            i_restart = 1'b0;
            r = $urandom_range(0, 119);
            if (r < 3) begin
                int c;
                c = $urandom_range(0, NCH - 1);
                m_d[c] = $urandom_range(0, 12);
                set_div(c, 16'(m_d[c]));
                i_restart = 1'b1;
            end else if (r < 7) begin
                int c;
                c = $urandom_range(0, NCH - 1);
                i_enable[c] = ~i_enable[c];
            end else if (r < 9) begin
                i_restart = 1'b1;
            end
            model_edge();
            step();
            chk($sformatf("rnd%0d_clk", t), 32'(o_clk), 32'(e_clk));
            chk($sformatf("rnd%0d_tick", t), 32'(o_tick), 32'(e_tick));
        end

        // Full-width divisor: one complete 65535-cycle period on channel 2
        i_enable  = 4'b0100;
        set_div(2, 16'hFFFF);
        i_restart = 1'b1;
        step();
        i_restart = 1'b0;
        hi      = 0;
        ticks   = 0;
        tick_at = -1;
        mid_hi  = 1'b0;
        mid_lo  = 1'b1;
        for (int k = 0; k < 65535; k++) begin
            step();
            if (o_clk[2]) hi++;
            if (o_tick[2]) begin
                ticks++;
                tick_at = k;
            end
            if (k == 32767) mid_hi = o_clk[2];
            if (k == 32768) mid_lo = o_clk[2];
        end
        chk("big_hi_cycles", 32'(hi), 32'd32768);
        chk("big_tick_count", 32'(ticks), 32'd1);
        chk("big_tick_pos", 32'(tick_at), 32'd65534);
        chk("big_last_hi", 32'(mid_hi), 32'd1);
        chk("big_first_lo", 32'(mid_lo), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
